// File: rtl/pipe_pkg.sv
// Shared pipeline-boundary constants: bundle widths, control field positions
// and the bubble (NOP) value used at each stage boundary.
package pipe_pkg;

    localparam int unsigned IF_ID_CTRL_W   = 8;
    localparam int unsigned IF_ID_DATA_W   = 64;
    localparam int unsigned ID_EX_CTRL_W   = 16;
    localparam int unsigned ID_EX_DATA_W   = 128;
    localparam int unsigned EX_MEM_CTRL_W  = 8;
    localparam int unsigned EX_MEM_DATA_W  = 96;
    localparam int unsigned MEM_WB_CTRL_W  = 4;
    localparam int unsigned MEM_WB_DATA_W  = 72;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    // ID/EX control bundle layout
    localparam int unsigned ID_EX_REG_WRITE_BIT  = 0;
    localparam int unsigned ID_EX_MEM_READ_BIT   = 1;
    localparam int unsigned ID_EX_MEM_WRITE_BIT  = 2;
    localparam int unsigned ID_EX_MEM_TO_REG_BIT = 3;
    localparam int unsigned ID_EX_ALU_SRC_BIT    = 4;
    localparam int unsigned ID_EX_BRANCH_BIT     = 5;
    localparam int unsigned ID_EX_ALU_OP_LSB     = 6;
    localparam int unsigned ID_EX_ALU_OP_W       = 4;

    // EX/MEM control bundle layout
    localparam int unsigned EX_MEM_REG_WRITE_BIT  = 0;
    localparam int unsigned EX_MEM_MEM_READ_BIT   = 1;
    localparam int unsigned EX_MEM_MEM_WRITE_BIT  = 2;
    localparam int unsigned EX_MEM_MEM_TO_REG_BIT = 3;

    // MEM/WB control bundle layout
    localparam int unsigned MEM_WB_REG_WRITE_BIT  = 0;
    localparam int unsigned MEM_WB_MEM_TO_REG_BIT = 1;

    // IF/ID control bundle layout
    localparam int unsigned IF_ID_BDS_BIT  = 0;
    localparam int unsigned IF_ID_PRED_BIT = 1;

    // Bubbles: every write-enable deasserted
    localparam logic [IF_ID_CTRL_W-1:0]  IF_ID_NOP  = '0;
    localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_NOP  = '0;
    localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_NOP = '0;
    localparam logic [MEM_WB_CTRL_W-1:0] MEM_WB_NOP = '0;

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// One valid+ctrl+data holding register. Clear dominates load; clearing
// returns ctrl to the bubble value but leaves the data bits alone.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned         CTRL_W   = ID_EX_CTRL_W,
    parameter int unsigned         DATA_W   = ID_EX_DATA_W,
    parameter logic [CTRL_W-1:0]   CTRL_NOP = '0
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (i_clear) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
        end else if (i_load) begin
            valid_d = 1'b1;
            ctrl_d  = i_ctrl;
            data_d  = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign o_valid = valid_q;
    assign o_ctrl  = ctrl_q;
    assign o_data  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline-stage register: valid/ready handshake, flush to bubble,
// optional 2-entry skid buffer and a saturating stall-cycle counter.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned         CTRL_W   = ID_EX_CTRL_W,
    parameter int unsigned         DATA_W   = ID_EX_DATA_W,
    parameter logic [CTRL_W-1:0]   CTRL_NOP = '0,
    parameter bit                  SKID     = 1'b1,
    parameter int unsigned         CNT_W    = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_flush,
    input  logic              i_cnt_clr,
    output logic [CNT_W-1:0]  o_stall_cnt
);

    logic              ready;
    logic              in_xfer, out_xfer;
    logic              out_valid, out_load, out_clear;
    logic [CTRL_W-1:0] out_ctrl, out_ld_ctrl;
    logic [DATA_W-1:0] out_data, out_ld_data;

    assign in_xfer  = i_valid & ready;
    assign out_xfer = out_valid & i_ready;

    pipe_slot #(
        .CTRL_W   (CTRL_W),
        .DATA_W   (DATA_W),
        .CTRL_NOP (CTRL_NOP)
    ) u_out (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (out_load),
        .i_clear (out_clear),
        .i_ctrl  (out_ld_ctrl),
        .i_data  (out_ld_data),
        .o_valid (out_valid),
        .o_ctrl  (out_ctrl),
        .o_data  (out_data)
    );

    generate
        if (SKID) begin : g_skid
            logic              skid_valid, skid_load, skid_drain;
            logic [CTRL_W-1:0] skid_ctrl;
            logic [DATA_W-1:0] skid_data;

            pipe_slot #(
                .CTRL_W   (CTRL_W),
                .DATA_W   (DATA_W),
                .CTRL_NOP (CTRL_NOP)
            ) u_skid (
                .i_clk   (i_clk),
                .i_reset (i_reset),
                .i_load  (skid_load),
                .i_clear (i_flush | skid_drain),
                .i_ctrl  (i_ctrl),
                .i_data  (i_data),
                .o_valid (skid_valid),
                .o_ctrl  (skid_ctrl),
                .o_data  (skid_data)
            );

            // Ready depends only on skid occupancy, so i_ready never reaches o_ready.
            assign ready = ~skid_valid;

            always_comb begin
                out_load    = 1'b0;
                out_clear   = i_flush;
                out_ld_ctrl = i_ctrl;
                out_ld_data = i_data;
                skid_load   = 1'b0;
                skid_drain  = 1'b0;
                if (!i_flush) begin
                    if (out_xfer && skid_valid) begin
                        out_load    = 1'b1;
                        out_ld_ctrl = skid_ctrl;
                        out_ld_data = skid_data;
                        skid_drain  = 1'b1;
                    end else if (in_xfer && (!out_valid || out_xfer)) begin
                        out_load = 1'b1;
                    end else if (in_xfer) begin
                        skid_load = 1'b1;
                    end else if (out_xfer) begin
                        out_clear = 1'b1;
                    end
                end
            end
        end else begin : g_single
            assign ready       = i_ready | ~out_valid;
            assign out_load    = in_xfer;
            assign out_clear   = i_flush | (out_xfer & ~in_xfer);
            assign out_ld_ctrl = i_ctrl;
            assign out_ld_data = i_data;
        end
    endgenerate

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (out_valid && !i_ready && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_ready     = ready;
    assign o_valid     = out_valid;
    assign o_ctrl      = out_valid ? out_ctrl : CTRL_NOP;
    assign o_data      = out_data;
    assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a skid-buffered instance and a
// single-slot instance with a 4-bit stall counter, sharing clock and reset.
module tb_pipe_stage_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 16;
    localparam logic [CW-1:0] NOP1 = 8'h3C;
    localparam logic [CW-1:0] NOP0 = 8'h5A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic          v1 = 1'b0, r1 = 1'b0, fl1 = 1'b0, clr1 = 1'b0;
    logic [CW-1:0] c1 = '0;
    logic [DW-1:0] d1 = '0;
    logic          ordy1, ov1;
    logic [CW-1:0] oc1;
    logic [DW-1:0] od1;
    logic [15:0]   cnt1;

    logic          v0 = 1'b0, r0 = 1'b0, fl0 = 1'b0, clr0 = 1'b0;
    logic [CW-1:0] c0 = '0;
    logic [DW-1:0] d0 = '0;
    logic          ordy0, ov0;
    logic [CW-1:0] oc0;
    logic [DW-1:0] od0;
    logic [3:0]    cnt0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(
        .CTRL_W   (CW),
        .DATA_W   (DW),
        .CTRL_NOP (NOP1),
        .SKID     (1'b1),
        .CNT_W    (16)
    ) u_dut_skid (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (v1),
        .o_ready     (ordy1),
        .i_ctrl      (c1),
        .i_data      (d1),
        .o_valid     (ov1),
        .i_ready     (r1),
        .o_ctrl      (oc1),
        .o_data      (od1),
        .i_flush     (fl1),
        .i_cnt_clr   (clr1),
        .o_stall_cnt (cnt1)
    );

    pipe_stage_reg #(
        .CTRL_W   (CW),
        .DATA_W   (DW),
        .CTRL_NOP (NOP0),
        .SKID     (1'b0),
        .CNT_W    (4)
    ) u_dut_single (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_valid     (v0),
        .o_ready     (ordy0),
        .i_ctrl      (c0),
        .i_data      (d0),
        .o_valid     (ov0),
        .i_ready     (r0),
        .o_ctrl      (oc0),
        .o_data      (od0),
        .i_flush     (fl0),
        .i_cnt_clr   (clr0),
        .o_stall_cnt (cnt0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state, both instances
        #1;
        check("rst_valid1", 32'(ov1), 32'd0);
        check("rst_ctrl1",  32'(oc1), 32'(NOP1));
        check("rst_data1",  32'(od1), 32'd0);
        check("rst_ready1", 32'(ordy1), 32'd1);
        check("rst_cnt1",   32'(cnt1), 32'd0);
        check("rst_valid0", 32'(ov0), 32'd0);
        check("rst_ctrl0",  32'(oc0), 32'(NOP0));
        check("rst_cnt0",   32'(cnt0), 32'd0);
        step();
        rst = 1'b0;

        // Fill out+skid while stalled, then reset asynchronously mid-cycle
        v1 = 1'b1; d1 = 16'h0055; c1 = 8'h77; r1 = 1'b0;
        step();
        d1 = 16'h0066;
        step();
        check("pre_rst_ready", 32'(ordy1), 32'd0);
        check("pre_rst_cnt",   32'(cnt1), 32'd1);
        #3 rst = 1'b1;
        #1;
        check("arst_valid", 32'(ov1), 32'd0);
        check("arst_ctrl",  32'(oc1), 32'(NOP1));
        check("arst_data",  32'(od1), 32'd0);
        check("arst_ready", 32'(ordy1), 32'd1);
        check("arst_cnt",   32'(cnt1), 32'd0);
        v1 = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_valid", 32'(ov1), 32'd0);

        // Streaming 1..8 with continuous ready: one beat per cycle, no gaps
        r1 = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            v1 = 1'b1; d1 = 16'(i); c1 = 8'(8'h10 + i);
            step();
            check("stream_valid", 32'(ov1), 32'd1);
            check("stream_data",  32'(od1), 32'(i));
            check("stream_ctrl",  32'(oc1), 32'(8'h10 + i));
        end
        v1 = 1'b0;
        step();
        check("stream_drain_valid", 32'(ov1), 32'd0);
        check("stream_drain_ctrl",  32'(oc1), 32'(NOP1));
        check("stream_cnt",         32'(cnt1), 32'd0);

        // Backpressure: A, B, C with ready low
        r1 = 1'b0; v1 = 1'b1; d1 = 16'h000A; c1 = 8'hA1;
        step();
        check("bp_a_ready", 32'(ordy1), 32'd1);
        d1 = 16'h000B; c1 = 8'hB2;
        step();
        check("bp_b_ready", 32'(ordy1), 32'd0);
        check("bp_b_data",  32'(od1), 32'h000A);
        d1 = 16'h000C; c1 = 8'hC3;
        step();
        check("bp_c_held_ready", 32'(ordy1), 32'd0);
        check("bp_c_held_data",  32'(od1), 32'h000A);
        check("bp_cnt2",         32'(cnt1), 32'd2);
        step();
        check("bp_cnt3",         32'(cnt1), 32'd3);
        r1 = 1'b1;
        step();
        check("bp_out_b",       32'(od1), 32'h000B);
        check("bp_out_b_ctrl",  32'(oc1), 32'hB2);
        check("bp_ready_again", 32'(ordy1), 32'd1);
        step();
        v1 = 1'b0;
        check("bp_out_c",       32'(od1), 32'h000C);
        check("bp_out_c_valid", 32'(ov1), 32'd1);
        step();
        check("bp_drained",     32'(ov1), 32'd0);
        check("bp_cnt_final",   32'(cnt1), 32'd3);

        // Flush with skid full; the beat 0xD offered meanwhile never appears
        r1 = 1'b0; v1 = 1'b1; d1 = 16'h0001; c1 = 8'h01;
        step();
        d1 = 16'h0002; c1 = 8'h02;
        step();
        check("fl_full_ready", 32'(ordy1), 32'd0);
        fl1 = 1'b1; d1 = 16'h000D; c1 = 8'hDD;
        step();
        fl1 = 1'b0;
        check("fl_valid", 32'(ov1), 32'd0);
        check("fl_ctrl",  32'(oc1), 32'(NOP1));
        check("fl_ready", 32'(ordy1), 32'd1);
        check("fl_cnt_kept", 32'(cnt1), 32'd5);
        // Flush while an input transfer is accepted: flush must win
        d1 = 16'h0003; c1 = 8'h03;
        step();
        fl1 = 1'b1; d1 = 16'h000D; c1 = 8'hDD;
        step();
        fl1 = 1'b0;
        check("fl2_valid", 32'(ov1), 32'd0);
        check("fl2_ready", 32'(ordy1), 32'd1);
        check("fl2_cnt",   32'(cnt1), 32'd6);
        r1 = 1'b1; d1 = 16'h000E; c1 = 8'hEE;
        step();
        v1 = 1'b0;
        check("fl_e_valid", 32'(ov1), 32'd1);
        check("fl_e_data",  32'(od1), 32'h000E);
        check("fl_e_ctrl",  32'(oc1), 32'hEE);
        step();
        check("fl_e_drain", 32'(ov1), 32'd0);

        // Single-slot: combinational ready and replace-on-transfer
        v0 = 1'b1; d0 = 16'h0011; c0 = 8'h11; r0 = 1'b0;
        step();
        check("s0_full_ready", 32'(ordy0), 32'd0);
        check("s0_data11",     32'(od0), 32'h0011);
        r0 = 1'b1; d0 = 16'h0022; c0 = 8'h22;
        #1;
        check("s0_comb_ready", 32'(ordy0), 32'd1);
        step();
        check("s0_data22",  32'(od0), 32'h0022);
        check("s0_ctrl22",  32'(oc0), 32'h22);
        check("s0_valid22", 32'(ov0), 32'd1);

        // Counter saturation at 15 with a 4-bit counter
        v0 = 1'b0; r0 = 1'b0;
        for (int i = 0; i < 14; i++) step();
        check("sat_cnt14", 32'(cnt0), 32'd14);
        for (int i = 0; i < 6; i++) step();
        check("sat_cnt15", 32'(cnt0), 32'd15);
        check("sat_data_held", 32'(od0), 32'h0022);
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("sat_clr", 32'(cnt0), 32'd0);
        step();
        check("sat_after_clr", 32'(cnt0), 32'd1);

        // Single-slot flush drops the simultaneously accepted beat
        r0 = 1'b1; v0 = 1'b1; d0 = 16'h0033; c0 = 8'h33; fl0 = 1'b1;
        step();
        fl0 = 1'b0; v0 = 1'b0;
        check("s0_fl_valid", 32'(ov0), 32'd0);
        check("s0_fl_ctrl",  32'(oc0), 32'(NOP0));
        step();
        check("s0_fl_stays", 32'(ov0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline-stage register. Successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle with a valid/ready handshake, synchronous flush (bubble insertion) and an optional 2-entry skid buffer.
- Includes a saturating stall-cycle counter for debug-unit readout.
- Sits between any two pipeline stages; one instance per stage boundary.

Parameters:
- CTRL_W, 16, width of control bundle (ALUOp, RegWrite, MemRead, ...).
- DATA_W, 128, width of data bundle (operands, immediate, register indices, BDS).
- CTRL_NOP, 0, control value presented for a bubble; must have all write-enables deasserted.
- SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single slot with combinational o_ready.
- CNT_W, 16, stall-counter width.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  upstream has a valid beat.
- o_ready  out  1  stage can accept a beat.
- i_ctrl  in  CTRL_W  upstream control bundle.
- i_data  in  DATA_W  upstream data bundle.
- o_valid  out  1  output beat valid.
- i_ready  in  1  downstream accepts.
- o_ctrl  out  CTRL_W  control bundle; equals CTRL_NOP whenever o_valid=0.
- o_data  out  DATA_W  data bundle; don't-care when o_valid=0.
- i_flush  in  1  synchronous kill of all held beats.
- i_cnt_clr  in  1  synchronous clear of stall counter.
- o_stall_cnt  out  CNT_W  cycles with o_valid=1 and i_ready=0.

Behaviour:
- Reset (async, i_reset=1):
  - out_valid=0, skid_valid=0.
  - Control regs=CTRL_NOP, data regs=0, counter=0.
  - Resulting outputs: o_valid=0, o_ctrl=CTRL_NOP, o_data=0, o_stall_cnt=0.
  - o_ready=1 while in reset when SKID=1.
  - Reset asserted mid-transfer discards all held beats.
- Handshakes: in_xfer = i_valid & o_ready; out_xfer = o_valid & i_ready.
- Latency: 1 cycle. A beat accepted at edge N into an empty stage appears with o_valid=1 after edge N.
- SKID=0:
  - o_ready = i_ready | ~out_valid (combinational).
  - On in_xfer: out slot <= input, out_valid <= 1.
  - Else on out_xfer: out_valid <= 0.
- SKID=1:
  - o_ready = ~skid_valid (registered; no combinational path from i_ready).
  - in_xfer with out slot empty or out_xfer: load out slot.
  - in_xfer with out slot full and no out_xfer: load skid slot, skid_valid <= 1.
  - out_xfer with skid_valid=1: out slot <= skid, skid_valid <= 0.
  - out_xfer with out slot only: out_valid <= 0 unless refilled by a simultaneous in_xfer.
  - Ordering is strict FIFO; no beat is lost or duplicated. Throughput is 1 beat/cycle under a continuous i_ready=1.
- Flush:
  - i_flush=1 at edge: out_valid <= 0, skid_valid <= 0, ctrl regs <= CTRL_NOP.
  - Flush dominates any same-cycle in_xfer; the incoming beat is dropped.
  - o_ready behaves normally during the flush cycle (upstream is flushed by the hazard unit in the same cycle).
  - The next cycle accepts beats normally.
- Stall (old i_enable=0 semantics): expressed as i_ready=0. Held beats and all registers stay unchanged.
- Counter:
  - Increments on each cycle with o_valid & ~i_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - i_cnt_clr wins over increment and loads 0.
  - Flush does not clear the counter.
- o_ctrl masking: o_ctrl = out_valid ? ctrl_reg : CTRL_NOP. Downstream never sees stale write-enables.

Decomposition:
- Shared package pipe_pkg holds:
  - Per-boundary bundle widths: IF_ID_CTRL_W, ID_EX_CTRL_W, EX_MEM_CTRL_W, MEM_WB_CTRL_W, and matching DATA_W constants.
  - Bit-position constants for fields within each control bundle.
  - Per-boundary NOP constants.
- One sub-module, pipe_slot: a single valid+ctrl+data register with load and clear inputs. Instantiated once (SKID=0) or twice (SKID=1); the top level holds the steering logic and the counter.

Test Plan:
- Reset, SKID=1: i_reset=1 mid-transfer -> o_valid=0, o_ctrl=0, o_data=0, o_ready=1, o_stall_cnt=0, all immediately (async).
- Streaming: i_valid=1, i_ready=1, data 1..8 on consecutive cycles -> o_data 1..8 on consecutive cycles, each 1 cycle later, no gaps.
- Backpressure, SKID=1:
  - Send A, B, C with i_ready=0 from cycle 1.
  - Expected: A in out slot, B in skid, o_ready=0, C held upstream.
  - Raise i_ready -> A, B, C delivered in order.
  - o_stall_cnt equals the number of i_ready=0 cycles with o_valid=1.
- Flush with skid full:
  - Assert i_flush for 1 cycle while i_valid=1 and data=0xD -> o_valid=0, o_ctrl=CTRL_NOP next cycle; 0xD is never output.
  - Next beat 0xE is output normally.
- Counter saturation, CNT_W=4: hold o_valid=1, i_ready=0 for 20 cycles -> o_stall_cnt=15. Then i_cnt_clr=1 with the stall still active -> 0.
- SKID=0 pass-through: out slot full, i_ready=1, i_valid=1 -> o_ready=1 in the same cycle; the new beat replaces the old one at the edge.
